// File: rtl/act_result_writer.sv
// act_result_writer: buffers activation beats in a show-ahead FIFO and issues them as addressed writes.
module act_result_writer #(
    parameter int FEATURE_WIDTH = 16,
    parameter int ADDR_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 16,
    parameter int ADDR_STEP     = 16
) (
    input  logic                          system_clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [ADDR_WIDTH-1:0]         base_addr,
    input  logic [15:0]                   beat_count,
    input  logic [FEATURE_WIDTH*8-1:0]    act_data,
    input  logic                          act_data_valid,
    output logic [FEATURE_WIDTH*8-1:0]    wr_data,
    output logic [ADDR_WIDTH-1:0]         wr_addr,
    output logic                          wr_valid,
    input  logic                          wr_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int DW = FEATURE_WIDTH * 8;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state;
    logic [DW-1:0]         mem [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [ADDR_WIDTH-1:0] base;
    logic [15:0]           count, accepted, issued, acc_next;
    logic [LW-1:0]         lvl_next;
    logic                  take, push, pop, full;

    assign full     = fifo_level == LW'(FIFO_DEPTH);
    assign wr_valid = state == RUN && fifo_level != '0;
    assign pop      = wr_valid && wr_ready;
    assign take     = state == RUN && act_data_valid && accepted < count;
    assign push     = take && (!full || pop);
    assign acc_next = accepted + 16'(take);
    assign lvl_next = fifo_level + LW'(push) - LW'(pop);
    assign wr_data  = wr_valid ? mem[rd_ptr] : '0;
    assign wr_addr  = base + ADDR_WIDTH'(issued) * ADDR_WIDTH'(ADDR_STEP);
    assign busy     = state == RUN;
    assign done     = state == DONE;

    always_ff @(posedge system_clk)
        if (push) mem[wr_ptr] <= act_data;

    // A dropped beat still counts as accepted, so the run ends once all pushed beats drain.
    always_ff @(posedge system_clk or negedge rst_n)
        if (!rst_n) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_level <= '0;
            accepted   <= '0;
            issued     <= '0;
            base       <= '0;
            count      <= '0;
            overflow   <= 1'b0;
        end else begin
            fifo_level <= lvl_next;
            accepted   <= acc_next;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                issued <= issued + 1'b1;
            end
            if (take && full && !pop) overflow <= 1'b1;
            if (state == IDLE && start) begin
                base     <= base_addr;
                count    <= beat_count;
                accepted <= '0;
                issued   <= '0;
                overflow <= 1'b0;
                state    <= beat_count == 16'd0 ? DONE : RUN;
            end else if (state == RUN && acc_next == count && lvl_next == '0)
                state <= DONE;
            else if (state == DONE)
                state <= IDLE;
        end
endmodule
